// File: rtl/match_pe_datapath.sv
// Pipelined match-length PE: two circular window buffers fed by one write stream,
// a registered byte compare and a registered leading-ones length encoder.

module match_pe_window #(
  parameter int SIZE_LOG2  = 15,
  parameter int PE_WIDTH   = 16,
  parameter int NBPIPE     = 3,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [PE_WIDTH*8-1:0]   wr_data,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [PE_WIDTH*8-1:0]   rd_data,
  output logic                    rd_unsafe
);
  localparam int OFF_W      = $clog2(PE_WIDTH);
  localparam int WORD_W     = SIZE_LOG2 - OFF_W;
  localparam int BANK_W     = WORD_W - 1;
  localparam int BANK_DEPTH = 1 << BANK_W;
  localparam int DW         = PE_WIDTH * 8;
  localparam logic [ADDR_WIDTH-1:0] WIN_BYTES = ADDR_WIDTH'(1) << SIZE_LOG2;

  // Even/odd word banks so an unaligned read fetches both spanned words in one access.
  logic [DW-1:0] mem_even [BANK_DEPTH];
  logic [DW-1:0] mem_odd  [BANK_DEPTH];

  logic [ADDR_WIDTH-1:0] wr_end_reg;
  logic [WORD_W-1:0]     wr_word;
  logic [WORD_W-1:0]     rd_word;
  logic [BANK_W-1:0]     odd_idx;
  logic [BANK_W-1:0]     even_idx;
  logic [ADDR_WIDTH-1:0] rd_end;
  logic                  unsafe_next;

  assign wr_word     = wr_addr[SIZE_LOG2-1:OFF_W];
  assign rd_word     = rd_addr[SIZE_LOG2-1:OFF_W];
  assign odd_idx     = rd_word[WORD_W-1:1];
  assign even_idx    = odd_idx + BANK_W'(rd_word[0]);
  assign rd_end      = rd_addr + ADDR_WIDTH'(PE_WIDTH);
  assign unsafe_next = (rd_end > wr_end_reg) || ((wr_end_reg - rd_addr) > WIN_BYTES);

  always_ff @(posedge clk) begin
    if (!rst_n) wr_end_reg <= '0;
    else if (wr_en) wr_end_reg <= wr_addr + ADDR_WIDTH'(PE_WIDTH);
  end

  logic [DW-1:0]    rd_even_reg;
  logic [DW-1:0]    rd_odd_reg;
  logic             par_reg;
  logic [OFF_W-1:0] off_reg;
  logic             unsafe_reg;

  always_ff @(posedge clk) begin
    if (wr_en && !wr_word[0]) mem_even[wr_word[WORD_W-1:1]] <= wr_data;
    if (wr_en &&  wr_word[0]) mem_odd[wr_word[WORD_W-1:1]]  <= wr_data;
    rd_even_reg <= mem_even[even_idx];
    rd_odd_reg  <= mem_odd[odd_idx];
    par_reg     <= rd_word[0];
    off_reg     <= rd_addr[OFF_W-1:0];
    unsafe_reg  <= unsafe_next;
  end

  logic [2*DW-1:0] pair;
  logic [DW-1:0]   aligned;

  assign pair    = par_reg ? {rd_even_reg, rd_odd_reg} : {rd_odd_reg, rd_even_reg};
  assign aligned = DW'(pair >> {off_reg, 3'b000});

  generate
    if (NBPIPE == 0) begin : g_nopipe
      assign rd_data   = aligned;
      assign rd_unsafe = unsafe_reg;
    end else begin : g_pipe
      logic [DW:0] pipe_reg [NBPIPE];
      always_ff @(posedge clk) begin
        pipe_reg[0] <= {unsafe_reg, aligned};
        for (int i = 1; i < NBPIPE; i++) pipe_reg[i] <= pipe_reg[i-1];
      end
      assign rd_data   = pipe_reg[NBPIPE-1][DW-1:0];
      assign rd_unsafe = pipe_reg[NBPIPE-1][DW];
    end
  endgenerate
endmodule

module match_pe_datapath #(
  parameter int IDX_W      = 2,
  parameter int NBPIPE     = 3,
  parameter int SIZE_LOG2  = 15,
  parameter int HEAD_LOG2  = 6,
  parameter int ADDR_WIDTH = 32,
  parameter int PE_WIDTH   = 16,
  parameter int LEN_W      = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_valid,
  input  logic [IDX_W-1:0]        i_idx,
  input  logic                    i_last,
  input  logic [ADDR_WIDTH-1:0]   i_head_addr,
  input  logic [ADDR_WIDTH-1:0]   i_history_addr,
  output logic                    o_valid,
  output logic                    o_last,
  output logic [IDX_W-1:0]        o_idx,
  output logic [LEN_W-1:0]        o_match_len,
  input  logic [ADDR_WIDTH-1:0]   i_write_addr,
  input  logic [PE_WIDTH*8-1:0]   i_write_data,
  input  logic                    i_write_enable,
  input  logic                    i_write_history_enable
);
  localparam int DW    = PE_WIDTH * 8;
  localparam int DEPTH = NBPIPE + 3;

  logic [DW-1:0] head_data;
  logic [DW-1:0] hist_data;
  logic          head_unsafe;
  logic          hist_unsafe;

  match_pe_window #(.SIZE_LOG2(HEAD_LOG2), .PE_WIDTH(PE_WIDTH), .NBPIPE(NBPIPE),
                    .ADDR_WIDTH(ADDR_WIDTH)) u_head (
    .clk(clk), .rst_n(rst_n), .wr_en(i_write_enable), .wr_addr(i_write_addr),
    .wr_data(i_write_data), .rd_addr(i_head_addr), .rd_data(head_data),
    .rd_unsafe(head_unsafe));

  match_pe_window #(.SIZE_LOG2(SIZE_LOG2), .PE_WIDTH(PE_WIDTH), .NBPIPE(NBPIPE),
                    .ADDR_WIDTH(ADDR_WIDTH)) u_history (
    .clk(clk), .rst_n(rst_n), .wr_en(i_write_enable && i_write_history_enable),
    .wr_addr(i_write_addr), .wr_data(i_write_data), .rd_addr(i_history_addr),
    .rd_data(hist_data), .rd_unsafe(hist_unsafe));

  logic [PE_WIDTH-1:0] eq_next;
  logic [PE_WIDTH-1:0] eq_reg;

  generate
    for (genvar gi = 0; gi < PE_WIDTH; gi++) begin : g_cmp
      assign eq_next[gi] = (hist_data[8*gi +: 8] == head_data[8*gi +: 8])
                           && !hist_unsafe && !head_unsafe;
    end
  endgenerate

  logic             can_ext;
  logic             run;
  logic [LEN_W-1:0] match_len;

  assign can_ext = &eq_reg;

  always_comb begin
    match_len = '0;
    run       = 1'b1;
    for (int k = 0; k < PE_WIDTH; k++) begin
      run       = run & eq_reg[k];
      match_len = match_len + LEN_W'(run);
    end
    if (can_ext) match_len = LEN_W'(PE_WIDTH);
  end

  // Tag side-band travels alongside the read, compare and length stages.
  logic [DEPTH-1:0]            vld_pipe_reg;
  logic [DEPTH-1:0]            last_pipe_reg;
  logic [DEPTH-1:0][IDX_W-1:0] idx_pipe_reg;
  logic [LEN_W-1:0]            len_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) vld_pipe_reg <= '0;
    else        vld_pipe_reg <= {vld_pipe_reg[DEPTH-2:0], i_valid};
    last_pipe_reg <= {last_pipe_reg[DEPTH-2:0], i_last};
    idx_pipe_reg  <= {idx_pipe_reg[DEPTH-2:0], i_idx};
    eq_reg        <= eq_next;
    len_reg       <= match_len;
  end

  assign o_valid     = vld_pipe_reg[DEPTH-1];
  assign o_last      = last_pipe_reg[DEPTH-1];
  assign o_idx       = idx_pipe_reg[DEPTH-1];
  assign o_match_len = len_reg;
endmodule

// File: tb/tb_match_pe_datapath.sv
// Directed bench for match_pe_datapath (NBPIPE=3, latency 6 cycles).

module tb_match_pe_datapath;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_valid = 1'b0;
  logic [1:0]   i_idx = '0;
  logic         i_last = 1'b0;
  logic [31:0]  i_head_addr = '0;
  logic [31:0]  i_history_addr = '0;
  logic         o_valid;
  logic         o_last;
  logic [1:0]   o_idx;
  logic [4:0]   o_match_len;
  logic [31:0]  i_write_addr = '0;
  logic [127:0] i_write_data = '0;
  logic         i_write_enable = 1'b0;
  logic         i_write_history_enable = 1'b0;

  int n_total = 0;
  int n_pass  = 0;

  match_pe_datapath dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_idx(i_idx), .i_last(i_last),
    .i_head_addr(i_head_addr), .i_history_addr(i_history_addr),
    .o_valid(o_valid), .o_last(o_last), .o_idx(o_idx), .o_match_len(o_match_len),
    .i_write_addr(i_write_addr), .i_write_data(i_write_data),
    .i_write_enable(i_write_enable), .i_write_history_enable(i_write_history_enable));

  always #5 clk = ~clk;

  function automatic logic [127:0] mk(input logic [7:0] base);
    logic [127:0] d;
    for (int k = 0; k < 16; k++) d[8*k +: 8] = base + 8'(k);
    return d;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    i_valid = 1'b0;
    i_write_enable = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [127:0] d, input logic he);
    i_write_addr = a;
    i_write_data = d;
    i_write_enable = 1'b1;
    i_write_history_enable = he;
    @(posedge clk);
    #1 i_write_enable = 1'b0;
  endtask

  task automatic set_q(input logic [31:0] h, input logic [31:0] hs,
                       input logic [1:0] idx, input logic lst);
    i_valid = 1'b1;
    i_head_addr = h;
    i_history_addr = hs;
    i_idx = idx;
    i_last = lst;
  endtask

  task automatic check_out(input string tag, input logic [1:0] idx, input logic lst,
                           input logic [4:0] len);
    $display("query %s: valid=%0d idx=%0d last=%0d len=%0d (want len=%0d)",
             tag, o_valid, o_idx, o_last, o_match_len, len);
    check({tag, ".valid"}, o_valid, 1);
    check({tag, ".len"}, o_match_len, len);
    check({tag, ".idx"}, o_idx, idx);
    check({tag, ".last"}, o_last, lst);
  endtask

  // Single query: issue, verify not early at cycle 5, then full result at cycle 6.
  task automatic query(input string tag, input logic [31:0] h, input logic [31:0] hs,
                       input logic [1:0] idx, input logic lst, input logic [4:0] len);
    set_q(h, hs, idx, lst);
    @(posedge clk);
    #1 i_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 check({tag, ".early"}, o_valid, 0);
    @(posedge clk);
    #1 check_out(tag, idx, lst, len);
  endtask

  logic [127:0] d_a;
  logic [127:0] d_b;

  initial begin
    // 1. reset and idle, then query before any write
    do_reset();
    for (int i = 0; i < 8; i++) begin
      check("idle.valid", o_valid, 0);
      @(posedge clk);
      #1;
    end
    query("nowrite", 0, 0, 1, 0, 0);

    // 2. identical data in both windows
    wr(0, mk(8'h00), 1'b1);
    query("full16", 0, 0, 2, 1, 16);

    // 3. head overwritten alone so byte 5, then byte 0, differ
    d_a = mk(8'h00);
    d_b = d_a;
    d_b[8*5 +: 8] = 8'hAA;
    wr(0, d_b, 1'b0);
    query("diff5", 0, 0, 3, 0, 5);
    d_b = d_a;
    d_b[7:0] = 8'hAA;
    wr(0, d_b, 1'b0);
    query("diff0", 0, 0, 0, 1, 0);

    // 4. unaligned two-word reads on 16-periodic data
    do_reset();
    wr(0, mk(8'h00), 1'b1);
    wr(16, mk(8'h00), 1'b1);
    wr(32, mk(8'h00), 1'b1);
    query("unal_eq", 20, 4, 1, 1, 16);
    query("unal_ne", 21, 4, 2, 0, 0);
    query("hist_end", 20, 36, 3, 0, 0);

    // 5. history never written; head beyond wr_end
    do_reset();
    wr(0, mk(8'h00), 1'b0);
    query("hist_unsafe", 0, 0, 1, 0, 0);
    wr(16, mk(8'h10), 1'b0);
    wr(32, mk(8'h20), 1'b0);
    wr(48, mk(8'h30), 1'b0);
    query("head_end", 60, 0, 2, 1, 0);

    // 6. 96 bytes written: stale head, valid compares, wrap, back-to-back
    do_reset();
    for (int a = 0; a < 96; a += 16) wr(32'(a), mk(8'(a)), 1'b1);
    query("stale", 0, 0, 0, 0, 0);
    set_q(32, 32, 0, 0);
    @(posedge clk);
    #1 set_q(32, 33, 1, 1);
    @(posedge clk);
    #1 set_q(40, 40, 2, 0);
    @(posedge clk);
    #1 set_q(56, 56, 3, 1);
    @(posedge clk);
    #1 i_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_out("b2b0", 0, 0, 16);
    @(posedge clk);
    #1 check_out("b2b1", 1, 1, 0);
    @(posedge clk);
    #1 check_out("b2b2", 2, 0, 16);
    @(posedge clk);
    #1 check_out("b2b3_wrap", 3, 1, 16);
    @(posedge clk);
    #1 check("b2b.after", o_valid, 0);

    // reset while a query is in flight discards it
    set_q(32, 32, 1, 1);
    @(posedge clk);
    #1 i_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("flush.valid", o_valid, 0);
      @(posedge clk);
      #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
